// File: rtl/bcd_scan_mux.sv
// -----------------------------------------------------------------------------
// bcd_scan_mux
//   Time-multiplexed digit scanner that feeds a BCD-to-7-segment decoder.
//   It holds an N-digit BCD value and presents one digit at a time, together
//   with an active-low common-anode enable. New values are double-buffered and
//   are committed only at the frame wrap, so an update never tears mid-scan.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   digits_in      BCD value; nibble i is digit i, digit 0 is rightmost
//   load           single-cycle strobe: capture digits_in into pending buffer
//   blank_lz       1 = blank leading zeros (digit 0 is never blanked)
//   bcd_out        BCD nibble of the scanned digit (0 when blanked)
//   an_n           active-low digit enables, at most one bit low
//   digit_idx      index of the scanned digit
//   frame_tick     one-cycle pulse following the frame wrap
//   update_pending pending buffer holds a value not yet committed
//
//   All outputs are registered and trail the scan index by one cycle.
// -----------------------------------------------------------------------------
module bcd_scan_mux #(
  parameter int NUM_DIGITS = 4,     // 2..8
  parameter int PRESCALE   = 50000  // >= 2 clk cycles per digit
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       digits_in,
  input  logic                          load,
  input  logic                          blank_lz,
  output logic [3:0]                    bcd_out,
  output logic [NUM_DIGITS-1:0]         an_n,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick,
  output logic                          update_pending
);

  localparam int IDX_W  = $clog2(NUM_DIGITS);
  localparam int PCNT_W = $clog2(PRESCALE);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PCNT_W-1:0] LAST_PCNT = PCNT_W'(PRESCALE - 1);

  // Scan state
  logic [PCNT_W-1:0]       r_pcnt;
  logic [IDX_W-1:0]        r_idx;

  // Double buffer
  logic [4*NUM_DIGITS-1:0] r_display;
  logic [4*NUM_DIGITS-1:0] r_pending;
  logic                    r_update_pending;

  // Output registers
  logic [3:0]              r_bcd_out;
  logic [NUM_DIGITS-1:0]   r_an_n;
  logic [IDX_W-1:0]        r_digit_idx;
  logic                    r_frame_tick;

  logic                    w_tick;
  logic                    w_commit;
  logic [3:0]              w_nib;
  logic                    w_upper_zero;
  logic                    w_show;
  logic [3:0]              w_bcd_next;
  logic [NUM_DIGITS-1:0]   w_an_n_next;

  assign w_tick   = (r_pcnt == LAST_PCNT);
  // The frame wraps when the last digit's slot expires.
  assign w_commit = w_tick && (r_idx == LAST_IDX);

  // ---------------------------------------------------------------------------
  // Prescaler and scan index
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcnt <= '0;
      r_idx  <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
      r_idx  <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
    end else begin
      r_pcnt <= r_pcnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending / display buffers. A load coinciding with the wrap bypasses the
  // pending stage so the newest value is never held back a whole frame.
  // ---------------------------------------------------------------------------
  // NOTE: the data buffers are reset as well, so a reset throws away any
  // pending value and the display comes back as all zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_display        <= '0;
      r_pending        <= '0;
      r_update_pending <= 1'b0;
    end else if (w_commit && load) begin
      r_display        <= digits_in;
      r_pending        <= digits_in;
      r_update_pending <= 1'b0;
    end else if (w_commit && r_update_pending) begin
      r_display        <= r_pending;
      r_update_pending <= 1'b0;
    end else if (load) begin
      r_pending        <= digits_in;
      r_update_pending <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Select the scanned nibble and find whether it and every more significant
  // nibble are zero (leading-zero run), walking from the top digit down.
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin : digit_select
    logic zero_run;
    zero_run     = 1'b1;
    w_nib        = '0;
    w_upper_zero = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (r_display[4*i +: 4] == 4'd0);
      if (r_idx == IDX_W'(i)) begin
        w_nib        = r_display[4*i +: 4];
        w_upper_zero = zero_run;
      end
    end
  end

  // Codes 10..15 have no decoder entry and are always blanked; digit 0 is
  // exempt from leading-zero blanking so a value of 0 still shows "0".
  assign w_show     = (w_nib <= 4'd9) &&
                      !(blank_lz && (r_idx != '0) && w_upper_zero);
  assign w_bcd_next = w_show ? w_nib : 4'd0;

  always_comb begin
    w_an_n_next = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_show && (r_idx == IDX_W'(i))) begin
        w_an_n_next[i] = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcd_out    <= '0;
      r_an_n       <= '1;
      r_digit_idx  <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_bcd_out    <= w_bcd_next;
      r_an_n       <= w_an_n_next;
      r_digit_idx  <= r_idx;
      r_frame_tick <= w_commit;
    end
  end

  assign bcd_out        = r_bcd_out;
  assign an_n           = r_an_n;
  assign digit_idx      = r_digit_idx;
  assign frame_tick     = r_frame_tick;
  assign update_pending = r_update_pending;

endmodule

// File: doc/bcd_scan_mux.md
Name: bcd_scan_mux

Overview:
- Time-multiplexed digit scanner sitting directly upstream of the BCD-to-7-segment decoder.
- Holds an N-digit BCD value and presents one digit at a time on bcd_out, which feeds the decoder's BCD input.
- Drives active-low common-anode enables in lockstep with bcd_out.
- New values are double-buffered and committed only at a frame boundary, so a display update never tears mid-scan.

Parameters:
- NUM_DIGITS, 4, number of display digits; legal range 2..8.
- PRESCALE, 50000, clk cycles each digit stays active; legal minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- digits_in  input  4*NUM_DIGITS  BCD value; nibble i is digit i, and digit 0 is the least significant (rightmost) digit.
- load  input  1  single-cycle strobe that captures digits_in into the pending buffer.
- blank_lz  input  1  when 1, leading zeros are blanked.
- bcd_out  output  4  BCD nibble of the currently scanned digit, sent to the decoder.
- an_n  output  NUM_DIGITS  active-low digit enables; at most one bit is 0.
- digit_idx  output  clog2(NUM_DIGITS)  index of the currently scanned digit.
- frame_tick  output  1  one-cycle pulse at frame wrap.
- update_pending  output  1  pending buffer holds data not yet committed.

Behaviour:
- Reset (asynchronous assert, synchronous release by clk):
  - prescale counter = 0, scan index = 0.
  - display register = 0, pending register = 0, update_pending = 0.
  - bcd_out = 0, an_n = all ones, digit_idx = 0, frame_tick = 0.
  - Reset asserted mid-frame or mid-update discards pending data immediately.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and wraps to 0.
  - tick = (pcnt == PRESCALE-1).
- Scan:
  - On tick, the index advances; it wraps from NUM_DIGITS-1 to 0.
  - Scan order is 0, 1, ..., N-1.
  - Each digit is active for exactly PRESCALE cycles; a frame is NUM_DIGITS*PRESCALE cycles.
- Outputs:
  - All outputs are registered and reflect the index state with one cycle of latency.
  - The first cycle after reset release shows an_n all ones.
  - From the second cycle on, an_n shows digit 0 enabled.
- frame_tick = 1 for exactly the one cycle in which the index wraps N-1 -> 0 (registered copy of that tick).
- Digit gating for index i, with d = display nibble i:
  - If d > 9: an_n[i] = 1 (blanked) and bcd_out = 0. The decoder has no entry for codes 10..15, so invalid codes are never forwarded.
  - Else, if blank_lz = 1, i != 0, and display nibbles i..N-1 are all 0: an_n[i] = 1 and bcd_out = 0.
  - Otherwise: an_n[i] = 0 and bcd_out = d.
  - Digit 0 is never leading-zero blanked, so value 0 shows a single "0".
- Load and commit:
  - load: pending <= digits_in and update_pending <= 1. Multiple loads before a commit: the last one wins.
  - Commit event = tick while the index is N-1, i.e. the frame wrap.
  - At the commit event, if update_pending: display <= pending and update_pending <= 0.
  - load in the same cycle as the commit event: the loaded digits_in goes straight to display and update_pending = 0.
  - load during any other cycle affects only the pending register; the displayed digits are unchanged until the next frame wrap.
- No combinational path from any input to any output.

Test Plan:
Setup: NUM_DIGITS=4, PRESCALE=4.
1. Reset, then release with no load -> an_n cycles 1110, 1101, 1011, 0111, each held 4 cycles, with bcd_out = 0 throughout; frame_tick pulses every 16 cycles; digit_idx follows the active digit.
2. load digits_in = 16'h1234 mid-frame -> update_pending = 1 until the next wrap; the following frame shows bcd_out 4, 3, 2, 1 on digits 0..3; update_pending returns to 0 at the wrap.
3. Display 16'h0007: with blank_lz = 1 -> only digit 0 enabled, bcd_out = 7, an_n = 1111 during digits 1..3; with blank_lz = 0 -> all digits enabled showing 7, 0, 0, 0.
4. Display 16'h0A05 -> digit 2 blanked (an_n = 1111, bcd_out = 0 in its slot); digits 0, 1, 3 show 5, 0, 0 with blank_lz = 0.
5. load 16'h1111, then load 16'h2222, then load 16'h3333 asserted exactly on the wrap cycle -> 16'h3333 is displayed in the next frame; 16'h1111 and 16'h2222 are never shown; update_pending = 0.
6. Assert rst_n = 0 mid-frame while update_pending = 1 -> outputs go to reset values immediately (an_n = 1111, update_pending = 0); after release the display shows 0000 and the pending data is lost.
